servo_gesture_seq: RTL
======================

# servo_gesture_seq

Sequencer between the gesture command inputs (Raspberry Pi pins or manual switches) and the three servo PWM generators. It does four things:
- selects the command source;
- synchronises and debounces the command;
- maps it to three target duty values;
- slews each channel's duty toward its target by a bounded step once per servo frame.

Duty outputs change only at frame boundaries, so the PWM generators never see a mid-period update.

## Interface
Parameters:
- PERIOD, 2000000 — frame length in clk cycles (20 ms at 100 MHz)
- STEP, 2500 — maximum duty change per channel per frame, in clk cycles
- STABLE_CYC, 100000 — cycles the synchronised command must hold before it is accepted

Ports:
- clk  in  1  system clock; one clock domain
- rst_n  in  1  asynchronous, active-low reset
- manual_on  in  1  1 selects sw, 0 selects rpi
- sw  in  2  manual gesture code
- rpi  in  2  Raspberry Pi gesture code (asynchronous)
- duty0, duty1, duty2  out  26  duty values to the PWM generators
- frame_tick  out  1  one-cycle pulse on the last cycle of each frame
- busy  out  1  high while any duty differs from its target
- gesture  out  2  currently accepted command code

## Operation
- Source mux: raw = manual_on ? sw : rpi. The mux output goes through a 2-flop synchroniser (sync).
- Debounce:
  - stab_cnt clears to 0 whenever sync changes; otherwise it increments, saturating at STABLE_CYC-1.
  - When stab_cnt == STABLE_CYC-1 and sync != gesture, gesture <= sync.
- Target table (duty0/duty1/duty2):
  - 00 → 100000/145000/145000
  - 01 → 50000/50000/50000
  - 10 → 100000/50000/145000
  - 11 → 75000/97500/97500
  - Targets are combinational from gesture.
- Frame counter: fcnt runs 0..PERIOD-1 and wraps. frame_tick = (fcnt == PERIOD-1).
- Slew, per channel, on each frame_tick:
  - if |target-duty| <= STEP: duty <= target
  - else: duty <= duty ± STEP, toward target
  - Compute the difference at 27 bits signed; no overflow or wrap is possible.
- FSM:
  - IDLE: all duties equal their targets. Go to RAMP when gesture changes to a code whose targets differ from the current duties.
  - RAMP: step on each frame_tick. Go to IDLE on the tick where all three channels land on target.
- Retarget mid-RAMP: the new target applies from the next frame_tick, starting from the current duty. There is no return-to-start and no extra frame of delay.
- busy = (state == RAMP). Equivalently, busy is high when any duty differs from its target.

## Timing
- Reset values:
  - duty0/1/2 = 50000
  - gesture = 01
  - sync = 01
  - stab_cnt = 0
  - fcnt = 0
  - frame_tick = 0
  - busy = 0
  - state = IDLE
- Reset asserted mid-ramp: all of the above apply immediately and asynchronously. The first frame_tick after deassertion comes PERIOD cycles later.
- Input to gesture latency: 2 synchroniser cycles plus STABLE_CYC cycles from the last input edge.
- gesture to first duty change: up to PERIOD cycles, i.e. the next frame_tick. The duty register updates on the clock edge where frame_tick=1 and is visible on the following cycle.
- gesture changing on the same cycle as frame_tick: that tick still uses the old target.
- A glitch shorter than STABLE_CYC never changes gesture.
- A change of manual_on is treated exactly like a command change and is debounced.
- Ramp length per channel: ceil(|Δ|/STEP) frames. busy falls on the cycle after the final tick.

## Configuration
- SERVO_SLEW_EN defined: slew behaviour as described above.
- SERVO_SLEW_EN not defined:
  - every channel loads its target directly on the next frame_tick (single-step jump);
  - STEP is ignored;
  - busy is high from the gesture change until that tick.

## Test plan
All scenarios use PERIOD=100, STEP=10000, STABLE_CYC=4 and SERVO_SLEW_EN defined unless noted.
1. Reset, then rpi=00 held → gesture=00 after 6 cycles. duty0 reaches 100000 after 5 ticks. duty1/duty2 go 60000, 70000, … 140000, 145000, reaching target on the 10th tick. busy falls after the 10th tick.
2. sw=11 with manual_on=0, rpi=01 → no change, busy=0. Then manual_on=1 → gesture=11 and duties ramp to 75000/97500/97500.
3. rpi pulses 01→10→01 for 3 cycles → gesture stays 01, duties stay 50000, busy=0.
4. Mid-ramp toward 00 (duty1=90000), switch to 01 → next tick duty1=80000, then down to 50000; no overshoot.
5. Assert rst_n=0 mid-ramp → all duties 50000, busy=0 and fcnt=0 immediately. After release, the first frame_tick occurs 100 cycles later.
6. SERVO_SLEW_EN undefined, rpi=00 → on the first tick after acceptance, duties = 100000/145000/145000 in one step.

Source files
------------

// File: rtl/servo_gesture_seq.sv
// servo_gesture_seq: debounced gesture command to three servo duty targets, updated once per frame; define SERVO_SLEW_EN to limit each frame's change to STEP, otherwise duties jump to target on the next frame
module servo_gesture_seq #(
    parameter int PERIOD     = 2000000,
    parameter int STEP       = 2500,
    parameter int STABLE_CYC = 100000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        manual_on,
    input  logic [1:0]  sw,
    input  logic [1:0]  rpi,
    output logic [25:0] duty0,
    output logic [25:0] duty1,
    output logic [25:0] duty2,
    output logic        frame_tick,
    output logic        busy,
    output logic [1:0]  gesture
);
    localparam int          FW    = $clog2(PERIOD + 1);
    localparam int          CW    = $clog2(STABLE_CYC + 1);
    localparam logic        IDLE  = 1'b0;
    localparam logic        RAMP  = 1'b1;
    localparam logic [25:0] D_RST = 26'd50000;

    logic [1:0]    w_raw;
    logic [1:0]    r_meta;
    logic [1:0]    r_sync;
    logic [1:0]    r_gesture;
    logic [1:0]    w_gesture_nx;
    logic [CW-1:0] r_stab_cnt;
    logic [FW-1:0] r_fcnt;
    logic [25:0]   r_duty [3];
    logic [25:0]   w_duty_nx [3];
    logic          w_diff_nx;
    logic          r_state;

    function automatic logic [25:0] tgt_of(input logic [1:0] g, input int c);
        case (g)
            2'b00:   return c == 0 ? 26'd100000 : 26'd145000;
            2'b01:   return 26'd50000;
            2'b10:   return c == 0 ? 26'd100000 : c == 1 ? 26'd50000 : 26'd145000;
            default: return c == 0 ? 26'd75000 : 26'd97500;
        endcase
    endfunction

    function automatic logic [25:0] slew(input logic [25:0] d, input logic [25:0] t);
`ifdef SERVO_SLEW_EN
        logic signed [26:0] diff;
        diff = $signed({1'b0, t}) - $signed({1'b0, d});
        if (diff > 27'sd0 && diff > $signed(27'(STEP)))
            return d + 26'(STEP);
        if (diff < 27'sd0 && -diff > $signed(27'(STEP)))
            return d - 26'(STEP);
`endif
        return t;
    endfunction

    assign frame_tick = r_fcnt == FW'(PERIOD - 1);
    assign duty0      = r_duty[0];
    assign duty1      = r_duty[1];
    assign duty2      = r_duty[2];
    assign busy       = r_state == RAMP;
    assign gesture    = r_gesture;

    // Next gesture, next duties (old target on a coincident tick) and whether anything will still be off target
    always_comb begin
        w_raw        = manual_on ? sw : rpi;
        w_gesture_nx = (r_stab_cnt == CW'(STABLE_CYC - 1) && r_sync != r_gesture) ? r_sync : r_gesture;
        w_diff_nx    = 1'b0;
        for (int c = 0; c < 3; c++) begin
            w_duty_nx[c] = frame_tick ? slew(r_duty[c], tgt_of(r_gesture, c)) : r_duty[c];
            w_diff_nx    = w_diff_nx | (w_duty_nx[c] != tgt_of(w_gesture_nx, c));
        end
    end

    // Two-flop synchroniser on the selected source, then hold-time debounce
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta     <= 2'b01;
            r_sync     <= 2'b01;
            r_stab_cnt <= '0;
            r_gesture  <= 2'b01;
        end else begin
            r_meta     <= w_raw;
            r_sync     <= r_meta;
            r_stab_cnt <= r_meta != r_sync ? '0 : r_stab_cnt == CW'(STABLE_CYC - 1) ? r_stab_cnt : r_stab_cnt + 1'b1;
            r_gesture  <= w_gesture_nx;
        end
    end

    // Free-running frame counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_fcnt <= '0;
        else
            r_fcnt <= frame_tick ? '0 : r_fcnt + 1'b1;
    end

    // Duty registers move only on the frame tick
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            for (int c = 0; c < 3; c++) r_duty[c] <= D_RST;
        else
            for (int c = 0; c < 3; c++) r_duty[c] <= w_duty_nx[c];
    end

    // RAMP exactly while some duty is (or is about to be) off its target
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= IDLE;
        else
            r_state <= w_diff_nx ? RAMP : IDLE;
    end
endmodule
